// File: rtl/aes_stream_ctrl_pkg.sv
// Shared constants, FSM encoding and response-word helpers for the AES stream command front-end.
`timescale 1ns/1ps
package aes_stream_ctrl_pkg;

    localparam int KEY_S    = 128;
    localparam int BLK_S    = 128;
    localparam int CTRL_S   = 3;
    localparam int STATUS_S = 4;

    localparam logic [CTRL_S-1:0] CTRL_KEY     = 3'd1;
    localparam logic [CTRL_S-1:0] CTRL_ENCRYPT = 3'd2;

    localparam logic [STATUS_S-1:0] S_KEY_MASK  = 4'b0001;
    localparam logic [STATUS_S-1:0] S_ENC_MASK  = 4'b0010;
    localparam logic [STATUS_S-1:0] S_BUSY_MASK = 4'b0100;
    localparam logic [STATUS_S-1:0] S_ERR_MASK  = 4'b1000;

    localparam int KEY_WORDS   = KEY_S / 32;
    localparam int BLK_WORDS   = BLK_S / 32;
    localparam int STAGE_S     = (KEY_S > BLK_S) ? KEY_S : BLK_S;
    localparam int STAGE_WORDS = STAGE_S / 32;

    localparam int          RESP_ERR_BIT      = 31;
    localparam logic [31:0] RESP_TIMEOUT_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_START,
        ST_WAIT,
        ST_SEND
    } state_t;

    function automatic logic is_known_ctrl(input logic [CTRL_S-1:0] code);
        return (code == CTRL_KEY) || (code == CTRL_ENCRYPT);
    endfunction

    function automatic int payload_words(input logic [CTRL_S-1:0] code);
        return (code == CTRL_KEY) ? KEY_WORDS : BLK_WORDS;
    endfunction

    function automatic logic [31:0] status_word(input logic err_bit, input logic [STATUS_S-1:0] st);
        logic [31:0] w;
        w                  = '0;
        w[STATUS_S-1:0]    = st;
        w[RESP_ERR_BIT]    = err_bit;
        return w;
    endfunction

endpackage

// File: rtl/aes_stream_ctrl.sv
// AXI-Stream command front-end for aes_top: loads key/plaintext packets, pulses en,
// waits for en_o (or times out) and serializes the status/ciphertext response.
`timescale 1ns/1ps
module aes_stream_ctrl
    import aes_stream_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [0:KEY_S-1]    aes_key,
    output logic [0:BLK_S-1]    aes_plaintext,
    input  logic [0:BLK_S-1]    aes_ciphertext,
    output logic [CTRL_S-1:0]   ctrl,
    output logic                en,
    input  logic [STATUS_S-1:0] status,
    input  logic                en_o,
    output logic                err
);

    localparam int WCNT_W = $clog2(STAGE_WORDS + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam int RCNT_W = $clog2(BLK_WORDS + 1);

    state_t              state;
    state_t              state_next;
    logic                take;
    logic                hdr_known;
    logic                last_word;
    logic                timeout_hit;
    logic                err_set;
    logic [CTRL_S-1:0]   hdr_code;
    logic [WCNT_W-1:0]   word_cnt;
    logic [WCNT_W-1:0]   need_words;
    logic [TCNT_W-1:0]   tmo_cnt;
    logic [RCNT_W-1:0]   resp_left;
    logic [0:STAGE_S-1]  stage;
    logic [0:STAGE_S-1]  stage_nx;
    logic [BLK_S-1:0]    resp_sr;

    assign take         = s_axis_tvalid && s_axis_tready;
    assign hdr_code     = s_axis_tdata[CTRL_S-1:0];
    assign hdr_known    = is_known_ctrl(hdr_code);
    assign last_word    = (word_cnt == need_words - WCNT_W'(1));
    assign timeout_hit  = (tmo_cnt == TCNT_W'(TIMEOUT - 1));
    assign m_axis_tdata = resp_sr[BLK_S-1 -: 32];

    // BOOT keeps s_axis_tready low for the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        case (state)
            ST_BOOT: state_next = ST_IDLE;
            ST_IDLE: begin
                if (take) begin
                    if (hdr_known && !s_axis_tlast) begin
                        state_next = ST_LOAD;
                    end else begin
                        err_set    = 1'b1;
                        state_next = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end
                end
            end
            ST_LOAD: begin
                if (take) begin
                    if (last_word && s_axis_tlast) begin
                        state_next = ST_START;
                    end else if (s_axis_tlast) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else if (last_word) begin
                        err_set    = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (take && s_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                // en_o takes priority over a timeout landing in the same cycle.
                if (en_o) begin
                    state_next = ST_SEND;
                end else if (timeout_hit) begin
                    err_set    = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_tready && (resp_left == RCNT_W'(1))) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        en            = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD, ST_DRAIN: s_axis_tready = 1'b1;
            ST_START:                   en            = 1'b1;
            ST_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (resp_left == RCNT_W'(1));
            end
            default: ;
        endcase
    end

    // Payload words assemble big-endian: first beat lands in bits [0:31].
    always_comb begin
        stage_nx = stage;
        if ((state == ST_LOAD) && take) begin
            stage_nx[int'(word_cnt)*32 +: 32] = s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        stage <= stage_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt      <= '0;
            need_words    <= '0;
            tmo_cnt       <= '0;
            resp_left     <= '0;
            resp_sr       <= '0;
            ctrl          <= '0;
            aes_key       <= '0;
            aes_plaintext <= '0;
            err           <= 1'b0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    word_cnt <= '0;
                    if (take && hdr_known && !s_axis_tlast) begin
                        ctrl       <= hdr_code;
                        need_words <= WCNT_W'(payload_words(hdr_code));
                    end
                end
                ST_LOAD: begin
                    if (take) begin
                        word_cnt <= word_cnt + WCNT_W'(1);
                        // Commit only a well-formed packet so a bad one leaves key/block untouched.
                        if (last_word && s_axis_tlast) begin
                            if (ctrl == CTRL_KEY) begin
                                aes_key <= stage_nx[0:KEY_S-1];
                            end else begin
                                aes_plaintext <= stage_nx[0:BLK_S-1];
                            end
                        end
                    end
                end
                ST_START: tmo_cnt <= '0;
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + TCNT_W'(1);
                    if (en_o) begin
                        if (ctrl == CTRL_KEY) begin
                            resp_sr   <= {status_word(1'b0, status), {(BLK_S-32){1'b0}}};
                            resp_left <= RCNT_W'(1);
                        end else begin
                            resp_sr   <= aes_ciphertext;
                            resp_left <= RCNT_W'(BLK_WORDS);
                        end
                    end else if (timeout_hit) begin
                        resp_sr   <= {RESP_TIMEOUT_WORD | status_word(1'b0, status), {(BLK_S-32){1'b0}}};
                        resp_left <= RCNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (m_axis_tready) begin
                        resp_sr   <= resp_sr << 32;
                        resp_left <= resp_left - RCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl: an aes_top stand-in with programmable latency,
// directed protocol/boundary steps plus randomized commands checked against a packet-level model.
`timescale 1ns/1ps
module tb_aes_stream_ctrl;
    import aes_stream_ctrl_pkg::*;

    localparam int TMO = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic                s_axis_tlast;
    logic [31:0]         m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic [0:KEY_S-1]    aes_key;
    logic [0:BLK_S-1]    aes_plaintext;
    logic [0:BLK_S-1]    aes_ciphertext;
    logic [CTRL_S-1:0]   ctrl;
    logic                en;
    logic [STATUS_S-1:0] status;
    logic                en_o;
    logic                err;

    aes_stream_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .aes_key(aes_key), .aes_plaintext(aes_plaintext), .aes_ciphertext(aes_ciphertext),
        .ctrl(ctrl), .en(en), .status(status), .en_o(en_o), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Stand-in cipher: the FIPS-197 C.1 vector, otherwise an order-sensitive mix of key and block.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'hc3a5_5a3c_0f1e_2d3c_4b5a_6978_8796_a5b4;
    endfunction

    int                  stub_delay;
    bit                  stub_hang;
    bit                  spur;
    logic                st_active;
    int                  st_down;
    logic [127:0]        st_ct;
    logic [STATUS_S-1:0] st_bits;
    logic                stub_eno;
    int                  en_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            st_active <= 1'b0;
            st_down   <= 0;
            st_ct     <= '0;
            st_bits   <= '0;
        end else if (en) begin
            st_active <= 1'b1;
            st_down   <= stub_delay;
            st_ct     <= cipher(aes_key, aes_plaintext);
            st_bits   <= st_bits | ((ctrl == CTRL_KEY) ? S_KEY_MASK : S_ENC_MASK);
        end else if (st_active) begin
            if (stub_eno) st_active <= 1'b0;
            if (st_down > 1) st_down <= st_down - 1;
        end
    end

    always @(posedge clk) if (en) en_cnt <= en_cnt + 1;

    assign stub_eno       = st_active && (st_down == 1) && !stub_hang;
    assign en_o           = stub_eno || spur;
    assign aes_ciphertext = st_ct;
    assign status         = st_bits | ((st_active && !stub_eno) ? S_BUSY_MASK : '0);

    int                  total = 0;
    int                  bad = 0;
    logic [127:0]        m_key;
    logic [127:0]        m_pt;
    logic [STATUS_S-1:0] m_bits;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] d, input bit last);
        int n;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", s_axis_tready, 1'b1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] code, input logic [127:0] pl, input int nwords, input int last_at);
        logic [31:0] hdr;
        hdr      = $urandom;
        hdr[2:0] = code;
        put(hdr, last_at == 0);
        for (int i = 0; i < nwords; i++) put(pl[127-32*i -: 32], (i + 1) == last_at);
    endtask

    task automatic get_resp(input logic [31:0] exp[$], input bit tog, input int explat);
        int cyc, idx, first;
        bit prev_stall, rdy;
        logic [31:0] prev_data;
        logic prev_last;
        cyc = 0; idx = 0; first = -1; prev_stall = 0; prev_data = '0; prev_last = 0;
        while (idx < exp.size() && cyc < 200) begin
            @(negedge clk);
            cyc++;
            rdy = tog ? ((cyc % 2) == 1) : 1'b1;
            if (m_axis_tvalid) begin
                if (first < 0) first = cyc;
                chk("in_blocked", s_axis_tready, 1'b0);
                if (prev_stall) begin
                    chk("stall_data", m_axis_tdata, prev_data);
                    chk("stall_last", m_axis_tlast, prev_last);
                end
                if (rdy) begin
                    chk($sformatf("resp_word%0d", idx), m_axis_tdata, exp[idx]);
                    chk($sformatf("resp_last%0d", idx), m_axis_tlast, idx == exp.size() - 1);
                    idx++;
                end
                prev_stall = !rdy;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
            m_axis_tready = rdy;
        end
        @(negedge clk);
        m_axis_tready = 1'b0;
        chk("resp_count", idx, exp.size());
        chk("resp_latency", first, explat);
        chk("resp_done", m_axis_tvalid, 1'b0);
        chk("idle_ready", s_axis_tready, 1'b1);
    endtask

    task automatic do_cmd(input logic [2:0] code, input logic [127:0] pl, input int dly, input bit tog);
        logic [31:0] exp[$];
        logic [127:0] ct;
        int e0;
        stub_delay = dly;
        e0 = en_cnt;
        send_cmd(code, pl, (code == CTRL_KEY) ? KEY_WORDS : BLK_WORDS, (code == CTRL_KEY) ? KEY_WORDS : BLK_WORDS);
        chk("en_pulse", en, 1'b1);
        chk("en_ctrl", ctrl, code);
        if (code == CTRL_KEY) begin
            m_key  = pl;
            m_bits = m_bits | S_KEY_MASK;
        end else begin
            m_pt   = pl;
            m_bits = m_bits | S_ENC_MASK;
        end
        if (stub_hang) begin
            exp.push_back(32'h8000_0000 | 32'(m_bits | S_BUSY_MASK));
        end else if (code == CTRL_KEY) begin
            exp.push_back(32'(m_bits));
        end else begin
            ct = cipher(m_key, m_pt);
            for (int i = 0; i < BLK_WORDS; i++) exp.push_back(ct[127-32*i -: 32]);
        end
        get_resp(exp, tog, stub_hang ? TMO + 1 : dly + 1);
        chk("en_count", en_cnt, e0 + 1);
        chk("key_value", aes_key, m_key);
        chk("pt_value", aes_plaintext, m_pt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0; spur = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_axis_tready, 1'b0);
        chk("rst_m_valid", m_axis_tvalid, 1'b0);
        chk("rst_m_last", m_axis_tlast, 1'b0);
        chk("rst_m_data", m_axis_tdata, 32'h0);
        chk("rst_en", en, 1'b0);
        chk("rst_ctrl", ctrl, 3'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_key", aes_key, 128'h0);
        chk("rst_pt", aes_plaintext, 128'h0);
        reset = 1'b0;
        m_key = '0; m_pt = '0; m_bits = '0;
        @(negedge clk);
        chk("rst_ready_rise", s_axis_tready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [127:0] r;
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        stub_delay = 1; stub_hang = 0; spur = 0; m_key = '0; m_pt = '0; m_bits = '0;
        do_reset();

        // FIPS-197 key load and encrypt (with backpressure).
        do_cmd(CTRL_KEY, FIPS_KEY, 3, 0);
        chk("fips_key", aes_key, FIPS_KEY);
        do_cmd(CTRL_ENCRYPT, FIPS_PT, 5, 1);
        chk("no_err", err, 1'b0);

        // en_o outside WAIT must not start a response.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_valid", m_axis_tvalid, 1'b0);
        chk("spur_ready", s_axis_tready, 1'b1);

        for (int it = 0; it < 10; it++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            do_cmd(($urandom_range(0, 1) == 0) ? CTRL_KEY : CTRL_ENCRYPT, r, $urandom_range(1, TMO), 1'($urandom_range(0, 1)));
        end

        // en_o arriving in the last cycle before timeout wins.
        do_cmd(CTRL_ENCRYPT, {$urandom, $urandom, $urandom, $urandom}, TMO, 0);
        chk("boundary_no_err", err, 1'b0);

        // Timeout response.
        stub_hang = 1;
        do_cmd(CTRL_KEY, {$urandom, $urandom, $urandom, $urandom}, 1, 0);
        stub_hang = 0;
        chk("timeout_err", err, 1'b1);
        do_reset();

        // Early tlast on payload word 2.
        e0 = en_cnt;
        send_cmd(CTRL_ENCRYPT, {$urandom, $urandom, $urandom, $urandom}, 2, 2);
        chk("early_err", err, 1'b1);
        chk("early_ready", s_axis_tready, 1'b1);
        repeat (3) @(negedge clk);
        chk("early_no_en", en_cnt, e0);
        do_cmd(CTRL_KEY, FIPS_KEY, 2, 0);
        do_reset();

        // Missing tlast: the following header-like beat must be drained, not decoded.
        e0 = en_cnt;
        send_cmd(CTRL_KEY, {$urandom, $urandom, $urandom, $urandom}, KEY_WORDS, 99);
        put(32'(CTRL_KEY), 1'b0);
        put($urandom, 1'b1);
        repeat (3) @(negedge clk);
        chk("late_err", err, 1'b1);
        chk("late_no_en", en_cnt, e0);
        chk("late_key_kept", aes_key, m_key);
        do_cmd(CTRL_ENCRYPT, {$urandom, $urandom, $urandom, $urandom}, 4, 1);
        do_reset();

        // Unknown code, then a header carrying tlast.
        e0 = en_cnt;
        put(32'h0000_0005, 1'b0);
        put($urandom, 1'b0);
        put($urandom, 1'b1);
        chk("unknown_err", err, 1'b1);
        do_reset();
        put(32'(CTRL_KEY), 1'b1);
        chk("hdr_last_err", err, 1'b1);
        chk("hdr_last_ready", s_axis_tready, 1'b1);
        chk("hdr_last_no_en", en_cnt, e0);
        do_cmd(CTRL_ENCRYPT, {$urandom, $urandom, $urandom, $urandom}, 2, 0);

        // Reset during WAIT.
        do_reset();
        stub_hang = 1;
        send_cmd(CTRL_KEY, {$urandom, $urandom, $urandom, $urandom}, KEY_WORDS, KEY_WORDS);
        repeat (5) @(negedge clk);
        stub_hang = 0;
        do_reset();
        do_cmd(CTRL_KEY, {$urandom, $urandom, $urandom, $urandom}, 2, 0);

        // Reset during SEND after one beat went out.
        stub_delay = 2;
        send_cmd(CTRL_ENCRYPT, {$urandom, $urandom, $urandom, $urandom}, BLK_WORDS, BLK_WORDS);
        for (int n = 0; n < 40 && !m_axis_tvalid; n++) @(negedge clk);
        chk("send_reached", m_axis_tvalid, 1'b1);
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        do_reset();
        do_cmd(CTRL_KEY, FIPS_KEY, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
